bcd_ex3_serial_encoder: RTL



---
 rtl/ex3_pkg.sv | 23 ++
 rtl/ex3_serial_add_fsm.sv | 62 ++++++
 rtl/bcd_ex3_serial_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/ex3_pkg.sv
// Shared types and constants for the serial BCD to Excess-3 encoder.
package ex3_pkg;

   typedef enum logic [2:0] {
      S0   = 3'd0,
      S1C0 = 3'd1,
      S1C1 = 3'd2,
      S2C0 = 3'd3,
      S2C1 = 3'd4,
      S3C0 = 3'd5,
      S3C1 = 3'd6
   } ex3_state_e;

   localparam logic [3:0] EX3_ADDEND = 4'b0011;
   localparam logic [3:0] EX3_MIN    = 4'd3;
   localparam logic [3:0] EX3_MAX    = 4'd12;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   function automatic logic ex3_maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ex3_serial_add_fsm.sv
// Mealy bit-serial "+3" adder: the state encodes bit position and carry.
module ex3_serial_add_fsm
   import ex3_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_bit,
   input  logic i_advance,
   input  logic i_restart,
   output logic o_sum,
   output logic o_last
);

   ex3_state_e r_state;
   ex3_state_e w_eff;
   ex3_state_e w_next;
   logic [1:0] w_pos;
   logic       w_carry;
   logic       w_addend;
   logic       w_cout;

   // State register, stepped once per accepted bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S0;
      end else if (i_advance) begin
         r_state <= w_next;
      end else begin
         r_state <= r_state;
      end
   end

   // A restart bit is evaluated as bit 0 of a fresh digit
   always_comb begin
      w_eff   = i_restart ? S0 : r_state;
      w_pos   = 2'd0;
      w_carry = 1'b0;
      case (w_eff)
         S0:      begin w_pos = 2'd0; w_carry = 1'b0; end
         S1C0:    begin w_pos = 2'd1; w_carry = 1'b0; end
         S1C1:    begin w_pos = 2'd1; w_carry = 1'b1; end
         S2C0:    begin w_pos = 2'd2; w_carry = 1'b0; end
         S2C1:    begin w_pos = 2'd2; w_carry = 1'b1; end
         S3C0:    begin w_pos = 2'd3; w_carry = 1'b0; end
         S3C1:    begin w_pos = 2'd3; w_carry = 1'b1; end
         default: begin w_pos = 2'd0; w_carry = 1'b0; end
      endcase
      w_addend = EX3_ADDEND[w_pos];
      o_sum    = i_bit ^ w_addend ^ w_carry;
      w_cout   = ex3_maj(i_bit, w_addend, w_carry);
      case (w_pos)
         2'd0:    w_next = w_cout ? S1C1 : S1C0;
         2'd1:    w_next = w_cout ? S2C1 : S2C0;
         2'd2:    w_next = w_cout ? S3C1 : S3C0;
         2'd3:    w_next = S0;
         default: w_next = S0;
      endcase
   end

   assign o_last = (r_state == S3C0) || (r_state == S3C1);

endmodule

// File: rtl/bcd_ex3_serial_encoder.sv
// Serial LSB-first BCD digit in, registered Excess-3 word out on valid/ready.
// Optional BCD_CHECK_EN adds a raw-digit shadow register and the bcd_err flag.
module bcd_ex3_serial_encoder
   import ex3_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_valid,
   input  logic       bit_first,
   output logic       bit_ready,
   output logic [3:0] ex3_out,
   output logic       ex3_valid,
   input  logic       ex3_ready,
   output logic       bcd_err
);

   logic       w_sum;
   logic       w_last;
   logic       w_accept;
   logic       w_restart;
   logic       w_load;
   logic [3:0] w_word;
   logic [2:0] r_asm;
   logic [3:0] r_out;
   logic       r_valid;

   // Only the completing bit can stall, and only on an undrained word
   assign bit_ready = !w_last || !r_valid || ex3_ready;
   assign w_accept  = bit_valid && bit_ready;
   assign w_restart = w_accept && bit_first;
   assign w_load    = w_accept && w_last && !bit_first;
   assign w_word    = {w_sum, r_asm};

   ex3_serial_add_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .i_bit     (bit_in),
      .i_advance (w_accept),
      .i_restart (w_restart),
      .o_sum     (w_sum),
      .o_last    (w_last)
   );

   // Sum bits shift in from the top so bit 0 lands at the LSB after four bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm <= 3'd0;
      end else if (w_accept) begin
         r_asm <= w_word[3:1];
      end else begin
         r_asm <= r_asm;
      end
   end

   // Output slot: a new load wins over consumption of the old word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= 4'd0;
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_out   <= w_word;
         r_valid <= 1'b1;
      end else if (r_valid && ex3_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   assign ex3_out   = r_out;
   assign ex3_valid = r_valid;

`ifdef BCD_CHECK_EN
   logic [2:0] r_bcd;
   logic       r_err;
   logic [3:0] w_raw;

   assign w_raw = {bit_in, r_bcd};

   // Shadow of the raw digit bits; the flag is loaded alongside the word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcd <= 3'd0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bcd <= w_raw[3:1];
         end else begin
            r_bcd <= r_bcd;
         end
         if (w_load) begin
            r_err <= (w_raw > BCD_MAX);
         end else begin
            r_err <= r_err;
         end
      end
   end

   assign bcd_err = r_err;
`else
   assign bcd_err = 1'b0;
`endif

endmodule
